// File: rtl/vending_sequencer.sv
// Vending sequencer: coin intake with credit ceiling, two-item selection, vend-motor
// handshake, greedy 5/2/1 change payout, cancel and inactivity-timeout refunds.
module vending_sequencer #(
    parameter int unsigned PRICE0      = 6,
    parameter int unsigned PRICE1      = 3,
    parameter int unsigned MAX_CREDIT  = 20,
    parameter int unsigned CREDIT_W    = 5,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_coin_valid,
    input  logic [1:0]          i_coin_val,
    output logic                o_coin_accept,
    output logic                o_coin_reject,
    input  logic                i_sel_valid,
    input  logic                i_sel_item,
    input  logic                i_cancel,
    output logic                o_denied,
    output logic                o_vend_req,
    output logic                o_vend_item,
    input  logic                i_vend_ack,
    output logic                o_chg_req,
    output logic [1:0]          o_chg_coin,
    input  logic                i_chg_ack,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_busy
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CREDIT_W-1:0] PRICE0_W   = CREDIT_W'(PRICE0);
    localparam logic [CREDIT_W-1:0] PRICE1_W   = CREDIT_W'(PRICE1);
    localparam logic [CREDIT_W:0]   MAX_W      = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StVend, StChange} state_e;

    // Coin code to CNY value; code 00 is worth nothing.
    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            2'b01:   coin_value = 3'd1;
            2'b10:   coin_value = 3'd2;
            2'b11:   coin_value = 3'd5;
            default: coin_value = 3'd0;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                vend_item_q, vend_item_d;
    logic                accept_q, accept_d;
    logic                reject_q, reject_d;
    logic                denied_q, denied_d;

    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W-1:0] price_sel;
    logic                in_intake;
    logic                cancel_win;
    logic                sel_ok;
    logic                coin_ok;
    logic [1:0]          chg_code;
    logic [CREDIT_W-1:0] chg_val;

    // Greedy payout coin chosen from the remaining credit.
    always_comb begin
        chg_code = 2'b01;
        if (credit_q >= CREDIT_W'(5)) begin
            chg_code = 2'b11;
        end else if (credit_q >= CREDIT_W'(2)) begin
            chg_code = 2'b10;
        end
        chg_val = CREDIT_W'(coin_value(chg_code));
    end

    // Arbitration of cancel > select > coin, then next-state and pulse decode.
    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        tmo_d       = '0;
        vend_item_d = vend_item_q;

        coin_sum   = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value(i_coin_val));
        price_sel  = i_sel_item ? PRICE1_W : PRICE0_W;
        in_intake  = (state_q == StIdle) || (state_q == StCollect);
        cancel_win = i_cancel && (state_q == StCollect);
        sel_ok     = i_sel_valid && !cancel_win && (state_q == StCollect)
                     && (credit_q >= price_sel);
        // A denied select does not consume the cycle, so a coin may still land.
        coin_ok    = i_coin_valid && !cancel_win && !sel_ok && in_intake
                     && (i_coin_val != 2'b00) && (coin_sum <= MAX_W);

        accept_d = coin_ok;
        reject_d = i_coin_valid && !coin_ok;
        denied_d = i_sel_valid && !cancel_win && !sel_ok;

        case (state_q)
            StIdle: begin
                if (coin_ok) begin
                    credit_d = coin_sum[CREDIT_W-1:0];
                    state_d  = StCollect;
                end
            end
            StCollect: begin
                if (cancel_win) begin
                    state_d = StChange;
                end else if (sel_ok) begin
                    credit_d    = credit_q - price_sel;
                    vend_item_d = i_sel_item;
                    state_d     = StVend;
                end else begin
                    if (coin_ok) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                    end
                    // Any coin or select attempt counts as activity.
                    if (coin_ok || i_sel_valid) begin
                        tmo_d = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = StChange;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            StVend: begin
                if (i_vend_ack) begin
                    state_d = (credit_q != '0) ? StChange : StIdle;
                end
            end
            StChange: begin
                if (credit_q == '0) begin
                    state_d = StIdle;
                end else if (i_chg_ack) begin
                    credit_d = credit_q - chg_val;
                    if (credit_q == chg_val) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and credit registers; synchronous active-low reset drops any credit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            credit_q    <= '0;
            tmo_q       <= '0;
            vend_item_q <= 1'b0;
            accept_q    <= 1'b0;
            reject_q    <= 1'b0;
            denied_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            tmo_q       <= tmo_d;
            vend_item_q <= vend_item_d;
            accept_q    <= accept_d;
            reject_q    <= reject_d;
            denied_q    <= denied_d;
        end
    end

    // Outputs decoded from registered state and credit only.
    always_comb begin
        o_coin_accept = accept_q;
        o_coin_reject = reject_q;
        o_denied      = denied_q;
        o_vend_req    = (state_q == StVend);
        o_vend_item   = vend_item_q;
        o_chg_req     = (state_q == StChange) && (credit_q != '0);
        o_chg_coin    = o_chg_req ? chg_code : 2'b00;
        o_credit      = credit_q;
        o_busy        = (state_q == StVend) || (state_q == StChange);
    end

endmodule

// File: tb/tb_vending_sequencer.sv
// Directed bench for vending_sequencer with an expectation queue and a credit model.
module tb_vending_sequencer;

    localparam int unsigned CREDIT_W = 5;
    localparam int unsigned TMO      = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                i_coin_valid = 1'b0;
    logic [1:0]          i_coin_val = 2'b00;
    logic                o_coin_accept;
    logic                o_coin_reject;
    logic                i_sel_valid = 1'b0;
    logic                i_sel_item = 1'b0;
    logic                i_cancel = 1'b0;
    logic                o_denied;
    logic                o_vend_req;
    logic                o_vend_item;
    logic                i_vend_ack = 1'b0;
    logic                o_chg_req;
    logic [1:0]          o_chg_coin;
    logic                i_chg_ack = 1'b0;
    logic [CREDIT_W-1:0] o_credit;
    logic                o_busy;

    vending_sequencer #(
        .PRICE0      (6),
        .PRICE1      (3),
        .MAX_CREDIT  (20),
        .CREDIT_W    (CREDIT_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_coin_valid  (i_coin_valid),
        .i_coin_val    (i_coin_val),
        .o_coin_accept (o_coin_accept),
        .o_coin_reject (o_coin_reject),
        .i_sel_valid   (i_sel_valid),
        .i_sel_item    (i_sel_item),
        .i_cancel      (i_cancel),
        .o_denied      (o_denied),
        .o_vend_req    (o_vend_req),
        .o_vend_item   (o_vend_item),
        .i_vend_ack    (i_vend_ack),
        .o_chg_req     (o_chg_req),
        .o_chg_coin    (o_chg_coin),
        .i_chg_ack     (i_chg_ack),
        .o_credit      (o_credit),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   m_credit = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL sb_empty: observed %0d, expected none queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s: observed %0d, expected %0d", e.tag, obs, e.exp);
        end
    endtask

    function automatic int coin_cny(input logic [1:0] code);
        case (code)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    // Insert one coin while in IDLE/COLLECT and check the response pulse and credit.
    task automatic coin(input logic [1:0] code);
        logic ok;
        ok = (code != 2'b00) && (m_credit + coin_cny(code) <= 20);
        if (ok) m_credit += coin_cny(code);
        push("coin_accept", 32'(ok));
        push("coin_reject", 32'(!ok));
        push("credit_after_coin", 32'(m_credit));
        i_coin_valid = 1'b1;
        i_coin_val   = code;
        tick();
        i_coin_valid = 1'b0;
        i_coin_val   = 2'b00;
        check(32'(o_coin_accept));
        check(32'(o_coin_reject));
        check(32'(o_credit));
    endtask

    // Select an item; success only from COLLECT (credit>0 here) with enough credit.
    task automatic sel(input logic item);
        int   price;
        logic ok;
        price = item ? 3 : 6;
        ok    = (m_credit != 0) && (m_credit >= price);
        if (ok) m_credit -= price;
        push("sel_denied", 32'(!ok));
        push("sel_vend_req", 32'(ok));
        push("sel_credit", 32'(m_credit));
        if (ok) push("sel_vend_item", 32'(item));
        i_sel_valid = 1'b1;
        i_sel_item  = item;
        tick();
        i_sel_valid = 1'b0;
        check(32'(o_denied));
        check(32'(o_vend_req));
        check(32'(o_credit));
        if (ok) check(32'(o_vend_item));
    endtask

    task automatic vend_ack();
        push("vend_req_after_ack", 0);
        push("chg_req_after_ack", 32'(m_credit != 0));
        push("busy_after_ack", 32'(m_credit != 0));
        i_vend_ack = 1'b1;
        tick();
        i_vend_ack = 1'b0;
        check(32'(o_vend_req));
        check(32'(o_chg_req));
        check(32'(o_busy));
    endtask

    // Pay out the model credit coin by coin, greedy 5/2/1, then expect IDLE.
    task automatic drain();
        int v;
        int guard;
        guard = 0;
        while (m_credit > 0 && guard < 20) begin
            v = (m_credit >= 5) ? 5 : (m_credit >= 2) ? 2 : 1;
            push("chg_req", 1);
            push("chg_coin", (v == 5) ? 3 : (v == 2) ? 2 : 1);
            check(32'(o_chg_req));
            check(32'(o_chg_coin));
            i_chg_ack = 1'b1;
            tick();
            i_chg_ack = 1'b0;
            m_credit -= v;
            guard++;
        end
        push("drain_chg_req", 0);
        push("drain_credit", 0);
        push("drain_busy", 0);
        check(32'(o_chg_req));
        check(32'(o_credit));
        check(32'(o_busy));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        push("rst_credit", 0);
        push("rst_busy", 0);
        push("rst_vend_req", 0);
        push("rst_chg_req", 0);
        push("rst_accept", 0);
        check(32'(o_credit));
        check(32'(o_busy));
        check(32'(o_vend_req));
        check(32'(o_chg_req));
        check(32'(o_coin_accept));
        rst = 1'b1;
        tick();

        // 1: exact payment, no change
        coin(2'b11);
        coin(2'b01);
        sel(1'b0);
        vend_ack();

        // 2: overpay, vend held until ack, change 2 then 1
        coin(2'b11);
        coin(2'b10);
        coin(2'b10);
        sel(1'b0);
        push("vend_req_held", 1);
        tick();
        check(32'(o_vend_req));
        vend_ack();
        drain();

        // 3: invalid coin, insufficient credit, cancel refund
        coin(2'b00);
        coin(2'b01);
        sel(1'b0);
        push("cancel_chg_req", 1);
        i_cancel = 1'b1;
        tick();
        i_cancel = 1'b0;
        check(32'(o_chg_req));
        drain();

        // 4: credit ceiling
        coin(2'b11);
        coin(2'b11);
        coin(2'b11);
        coin(2'b10);
        coin(2'b01);
        coin(2'b11);
        coin(2'b10);
        i_cancel = 1'b1;
        tick();
        i_cancel = 1'b0;
        drain();

        // 5: inactivity timeout
        coin(2'b10);
        for (int i = 0; i < TMO - 1; i++) begin
            push("tmo_not_yet", 0);
            tick();
            check(32'(o_chg_req));
        end
        tick();
        drain();

        // 6: coin loses to a same-cycle successful select, then reset mid-vend
        coin(2'b11);
        coin(2'b10);
        m_credit -= 3;
        push("race_reject", 1);
        push("race_accept", 0);
        push("race_vend_req", 1);
        push("race_vend_item", 1);
        push("race_credit", 32'(m_credit));
        i_coin_valid = 1'b1;
        i_coin_val   = 2'b01;
        i_sel_valid  = 1'b1;
        i_sel_item   = 1'b1;
        tick();
        i_coin_valid = 1'b0;
        i_coin_val   = 2'b00;
        i_sel_valid  = 1'b0;
        check(32'(o_coin_reject));
        check(32'(o_coin_accept));
        check(32'(o_vend_req));
        check(32'(o_vend_item));
        check(32'(o_credit));
        rst = 1'b0;
        m_credit = 0;
        push("midrst_vend_req", 0);
        push("midrst_busy", 0);
        push("midrst_credit", 0);
        push("midrst_vend_item", 0);
        push("midrst_chg_req", 0);
        tick();
        check(32'(o_vend_req));
        check(32'(o_busy));
        check(32'(o_credit));
        check(32'(o_vend_item));
        check(32'(o_chg_req));
        rst = 1'b1;
        push("post_rst_busy", 0);
        tick();
        check(32'(o_busy));

        // Select while IDLE is denied
        sel(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
